// File: rtl/vga_timing_if.sv
// Raster-side signal bundle of the VGA timing generator: the sampled divided
// clock in, and the sync / blanking / coordinate outputs.
interface vga_timing_if;
   logic       clk_0;
   logic       pix_tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_start;

   modport master (
      input  clk_0,
      output pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
   );

   modport slave (
      output clk_0,
      input  pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: turns rising edges of the sampled clk_0 into pixel ticks
// and advances h/v counters, with sync and blanking decoded in the same cycle.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   function automatic logic sync_level(input logic [9:0] cnt,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
      return (cnt >= lo && cnt <= hi) ? SYNC_POL : ~SYNC_POL;
   endfunction

   logic       s1, s2, s3;
   logic       vld_p0;
   logic [9:0] h_cnt, v_cnt;
   logic [9:0] h_nxt, v_nxt;
   logic       h_wrap, frame_wrap;
   logic       hsync_q, vsync_q, video_on_q, frame_start_q;

   always_comb begin
      h_wrap     = (h_cnt == H_LAST);
      frame_wrap = h_wrap && (v_cnt == V_LAST);
      h_nxt      = h_cnt + 10'd1;
      v_nxt      = v_cnt;
      if (h_wrap) begin
         h_nxt = '0;
         v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         s3            <= 1'b0;
         vld_p0        <= 1'b0;
         h_cnt         <= '0;
         v_cnt         <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // stage p0: synchronise clk_0 and detect its rising edge
         s1     <= vga.clk_0;
         s2     <= s1;
         s3     <= s2;
         vld_p0 <= s2 & ~s3;

         // stage p1: advance raster; decode from next counts so outputs align
         frame_start_q <= vld_p0 & frame_wrap;
         if (vld_p0) begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            hsync_q    <= sync_level(h_nxt, HS_LO, HS_HI);
            vsync_q    <= sync_level(v_nxt, VS_LO, VS_HI);
            video_on_q <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         end
      end
   end

   assign vga.pix_tick    = vld_p0;
   assign vga.pixel_x     = h_cnt;
   assign vga.pixel_y     = v_cnt;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster so whole frames fit
// in a short run; expected raster states are queued as clk_0 edges are driven.
`timescale 1ns/100ps
module tb_vga_timing_gen;

   localparam int HA = 20, HF = 4, HS = 6, HB = 4;
   localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam logic [23:0] RST_STATE = {1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};

   logic clk = 1'b0;
   logic rst_n;
   logic clk_0;

   vga_timing_if vif ();
   assign vif.clk_0 = clk_0;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .vga  (vif.master)
   );

   always #2 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          mx = 0, my = 0;
   int          pushed = 0, ticks_seen = 0, exp_fs = 0, fs_seen = 0;
   logic [23:0] sb_q[$];
   logic [23:0] cur;
   logic        pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [23:0] exp_of(input int x, input int y, input bit fs);
      logic hs, vs, von;
      hs  = !(x >= HA + HF && x < HA + HF + HS);
      vs  = !(y >= VA + VF && y < VA + VF + VS);
      von = (x < HA) && (y < VA);
      return {fs, von, vs, hs, 10'(y), 10'(x)};
   endfunction

   function automatic logic [23:0] obs_state();
      return {vif.frame_start, vif.video_on, vif.vsync, vif.hsync, vif.pixel_y, vif.pixel_x};
   endfunction

   task automatic push_next();
      bit fs;
      fs = (mx == HT - 1) && (my == VT - 1);
      if (mx == HT - 1) begin
         mx = 0;
         my = (my == VT - 1) ? 0 : my + 1;
      end else begin
         mx = mx + 1;
      end
      if (fs) exp_fs++;
      sb_q.push_back(exp_of(mx, my, fs));
      pushed++;
   endtask

   // One clk_0 period: high for hi cycles, low for lo cycles (lo >= 1).
   task automatic tick_pix(input int hi, input int lo);
      @(negedge clk);
      clk_0 = 1'b1;
      push_next();
      repeat (hi) @(negedge clk);
      clk_0 = 1'b0;
      repeat (lo - 1) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         cur  = RST_STATE;
         pend = 1'b0;
         chk("rst_state", 32'(obs_state()), 32'(RST_STATE));
         chk("rst_tick", 32'(vif.pix_tick), 32'd0);
      end else begin
         if (pend) begin
            chk("sb_avail", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) cur = sb_q.pop_front();
         end
         chk("raster", 32'(obs_state()), 32'(cur));
         cur[23] = 1'b0;
         chk("tick_width", 32'(pend & vif.pix_tick), 32'd0);
         if (vif.pix_tick) ticks_seen++;
         if (vif.frame_start) fs_seen++;
         pend = vif.pix_tick;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cur   = RST_STATE;
      pend  = 1'b0;
      rst_n = 1'b0;
      clk_0 = 1'b0;

      // Reset held while clk_0 toggles every clk
      repeat (12) begin
         @(negedge clk);
         clk_0 = ~clk_0;
      end
      clk_0 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Nominal divide-by-4 clk_0: just over one full frame
      repeat (HT * VT + 12) tick_pix(2, 2);

      // Maximum tick rate
      repeat (30) tick_pix(1, 1);

      // Sub-cycle glitches fall between edges and must never tick
      repeat (5) begin
         @(posedge clk);
         #1 clk_0 = 1'b1;
         #0.5 clk_0 = 1'b0;
         repeat (4) @(negedge clk);
      end

      // Land on (10,5) and park clk_0 high for 1000 cycles
      while (!(mx == 9 && my == 5)) tick_pix(1, 1);
      tick_pix(1000, 3);

      // Async reset mid-frame at (25,8)
      while (!(mx == 25 && my == 8)) tick_pix(2, 2);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #0.5;
      chk("async_rst", 32'(obs_state()), 32'(RST_STATE));
      chk("async_tick", 32'(vif.pix_tick), 32'd0);
      mx = 0;
      my = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Restart from (0,0): first tick lands on (1,0) with video on
      repeat (HT * VT + 5) tick_pix(2, 2);

      repeat (8) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      chk("tick_cnt", 32'(ticks_seen), 32'(pushed));
      chk("fs_cnt", 32'(fs_seen), 32'(exp_fs));
      chk("fs_total", 32'(exp_fs), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
